// File: rtl/weight_load_pkg.sv
// Shared types and sizes for the weight load path (stream packer and weight_manager).
package weight_load_pkg;

   localparam int IN_BYTES  = 8;
   localparam int OUT_BYTES = 9;
   localparam int BUF_BYTES = 16;
   localparam int LEVEL_W   = $clog2(BUF_BYTES + 1);

   typedef logic [OUT_BYTES*8-1:0] weight_word_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } load_state_t;

endpackage

// File: rtl/byte_gearbox_64to72.sv
// 16-byte stream-ordered buffer: appends 8-byte beats and pops 9-byte words.
module byte_gearbox_64to72
   import weight_load_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [IN_BYTES*8-1:0] in_data,
   input  logic                  emit,
   output logic [LEVEL_W-1:0]    level,
   output logic                  word_valid,
   output weight_word_t          word_data
);

   localparam int BUF_W = BUF_BYTES * 8;
   localparam int IN_W  = IN_BYTES * 8;

   logic [BUF_W-1:0]   flat_q;
   logic [BUF_W-1:0]   shifted;
   logic [BUF_W-1:0]   ins;
   logic [BUF_W-1:0]   mask;
   logic [BUF_W-1:0]   flat_n;
   logic [LEVEL_W-1:0] base;
   logic [LEVEL_W-1:0] level_n;
   logic [7:0]         sh;

   // Oldest byte lives at bit 0; popping a word is a right shift by 9 bytes.
   always_comb begin
      shifted = emit ? (flat_q >> (OUT_BYTES * 8)) : flat_q;
      base    = emit ? (level - LEVEL_W'(OUT_BYTES)) : level;
      sh      = {3'b000, base} << 3;
      ins     = {{(BUF_W - IN_W){1'b0}}, in_data} << sh;
      mask    = {{(BUF_W - IN_W){1'b0}}, {IN_W{1'b1}}} << sh;
      flat_n  = accept ? ((shifted & ~mask) | ins) : shifted;
      level_n = level;
      if (accept) level_n = level_n + LEVEL_W'(IN_BYTES);
      if (emit)   level_n = level_n - LEVEL_W'(OUT_BYTES);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flat_q     <= '0;
         level      <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
      end else begin
         word_valid <= emit;
         if (emit) word_data <= flat_q[OUT_BYTES*8-1:0];
         if (clear) begin
            flat_q <= '0;
            level  <= '0;
         end else begin
            flat_q <= flat_n;
            level  <= level_n;
         end
      end
   end

endmodule

// File: rtl/weight_stream_packer.sv
// Repacks a 64-bit AXI4-Stream of weight bytes into 72-bit weight_manager writes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; flags hold result of last load
// ST_LOAD  | accepting beats until beats_left hits 0 or early tlast
// ST_FLUSH | draining complete words left in the buffer
// ST_DONE  | one-cycle done pulse, buffer already cleared
module weight_stream_packer
   import weight_load_pkg::load_state_t, weight_load_pkg::ST_IDLE, weight_load_pkg::ST_LOAD,
          weight_load_pkg::ST_FLUSH, weight_load_pkg::ST_DONE, weight_load_pkg::LEVEL_W;
#(
   parameter int CNT_WIDTH = 18,
   parameter int IN_BYTES  = 8,
   parameter int OUT_BYTES = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [CNT_WIDTH-1:0]   num_words,
   input  logic [IN_BYTES*8-1:0]  s_tdata,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic                   s_tlast,
   output logic                   wr_en,
   output logic [OUT_BYTES*8-1:0] wr_data,
   output logic                   busy,
   output logic                   done,
   output logic                   err_short,
   output logic                   err_long
);

   localparam int BEAT_W = CNT_WIDTH + 1;

   load_state_t          state;
   logic [CNT_WIDTH-1:0] words_left;
   logic [BEAT_W-1:0]    beats_left;
   logic [BEAT_W-1:0]    n_ext;
   logic [BEAT_W-1:0]    n_round;
   logic [BEAT_W-1:0]    beats_calc;
   logic [LEVEL_W-1:0]   level;
   logic                 accept;
   logic                 emit;
   logic                 flush_fin;

   // ceil(9n/8) == n + ceil(n/8), which avoids a wide multiply.
   assign n_ext      = {1'b0, num_words};
   assign n_round    = n_ext + BEAT_W'(IN_BYTES - 1);
   assign beats_calc = n_ext + (n_round >> $clog2(IN_BYTES));

   assign s_tready  = (state == ST_LOAD) && (beats_left != '0);
   assign accept    = s_tvalid && s_tready;
   assign emit      = ((state == ST_LOAD) || (state == ST_FLUSH))
                      && (level >= LEVEL_W'(OUT_BYTES)) && (words_left != '0);
   // Wait for the registered write to leave the port before signalling done.
   assign flush_fin = (state == ST_FLUSH) && !emit && !wr_en;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   byte_gearbox_64to72 u_gearbox (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush_fin),
      .accept     (accept),
      .in_data    (s_tdata),
      .emit       (emit),
      .level      (level),
      .word_valid (wr_en),
      .word_data  (wr_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         words_left <= '0;
         beats_left <= '0;
         err_short  <= 1'b0;
         err_long   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  words_left <= num_words;
                  beats_left <= beats_calc;
                  err_short  <= 1'b0;
                  err_long   <= 1'b0;
                  state      <= (num_words == '0) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (emit) words_left <= words_left - 1'b1;
               if (accept) begin
                  if (beats_left == BEAT_W'(1)) begin
                     beats_left <= '0;
                     if (!s_tlast) err_long <= 1'b1;
                     state <= ST_FLUSH;
                  end else if (s_tlast) begin
                     beats_left <= '0;
                     err_short  <= 1'b1;
                     state      <= ST_FLUSH;
                  end else begin
                     beats_left <= beats_left - 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               if (emit) words_left <= words_left - 1'b1;
               if (flush_fin) state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_stream_packer.sv
// Scoreboard bench: driver pushes expected 9-byte words, monitor pops on every wr_en.
module tb_weight_stream_packer;

   localparam int CW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] num_words;
   logic [63:0]   s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic          wr_en;
   logic [71:0]   wr_data;
   logic          busy;
   logic          done;
   logic          err_short;
   logic          err_long;

   always #5 clk = ~clk;

   weight_stream_packer #(.CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_words (num_words),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tlast   (s_tlast),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .err_short (err_short),
      .err_long  (err_long)
   );

   int          checks = 0;
   int          errors = 0;
   int          wr_seen = 0;
   int          done_seen = 0;
   bit          ready_seen = 0;
   logic [71:0] exp_q[$];
   logic [7:0]  stream[$];

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            wr_seen++;
            check("wr_en_only_when_busy", 72'(busy), 72'(1));
            if (exp_q.size() == 0) check("unexpected_write", wr_data, 72'hx);
            else check("wr_data", wr_data, exp_q.pop_front());
         end
         if (done) done_seen++;
         if (s_tready) ready_seen = 1'b1;
      end
   end

   function automatic bit tlast_of(input int b, input int req, input int kind, input int sb);
      return (kind == 0 && b == req - 1) || (kind == 1 && b == sb);
   endfunction

   function automatic logic [63:0] beat_data(input int b);
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = stream[b*8 + k];
      return d;
   endfunction

   // kind: 0 tlast on final required beat, 1 tlast on beat sb, 2 no tlast at all
   // mode: 0 continuous tvalid, 1 toggling, 2 random
   task automatic run_cmd(input int n, input int mode, input int kind, input int sb,
                          input bit incr, input bit reuse, input bit mid_start);
      int req, taken, nwords, b, cyc;
      bit exp_short, exp_long, fire;
      logic [71:0] word;
      req = (9*n + 7) / 8;
      if (!reuse) begin
         stream.delete();
         for (int i = 0; i < (req + 4) * 8; i++)
            stream.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
      end
      exp_short = 1'b0;
      taken = req;
      for (int i = 0; i < req - 1; i++) begin
         if (tlast_of(i, req, kind, sb)) begin
            exp_short = 1'b1;
            taken = i + 1;
            break;
         end
      end
      exp_long = (req > 0) && !exp_short && !tlast_of(req - 1, req, kind, sb);
      nwords = (taken * 8) / 9;
      if (nwords > n) nwords = n;
      for (int w = 0; w < nwords; w++) begin
         for (int k = 0; k < 9; k++) word[8*k +: 8] = stream[9*w + k];
         exp_q.push_back(word);
      end

      wr_seen = 0;
      done_seen = 0;
      ready_seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      num_words = CW'(n);
      @(negedge clk);
      start = 1'b0;
      check("flags_cleared_on_start", 72'({err_short, err_long}), 72'(0));
      if (n == 0) check("zero_words_done_latency", 72'(done), 72'(1));

      b = 0;
      cyc = 0;
      while (b < taken && cyc < 2000) begin
         case (mode)
            0:       s_tvalid = 1'b1;
            1:       s_tvalid = (cyc % 2 == 0);
            default: s_tvalid = ($urandom_range(0, 3) != 0);
         endcase
         s_tdata = beat_data(b);
         s_tlast = tlast_of(b, req, kind, sb);
         start = mid_start && (cyc == 6);
         if (mid_start && cyc == 6) num_words = CW'(5);
         fire = s_tvalid && s_tready;
         @(negedge clk);
         if (fire) b++;
         cyc++;
      end
      start = 1'b0;
      check("beats_accepted", 72'(b), 72'(taken));

      // Next layer's data waiting on the bus must not be consumed.
      s_tvalid = 1'b1;
      s_tdata = beat_data(b);
      s_tlast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("tready_low_after_load", 72'(s_tready), 72'(0));
         @(negedge clk);
      end
      s_tvalid = 1'b0;

      cyc = 0;
      while (done_seen == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      check("done_pulses", 72'(done_seen), 72'(1));
      check("word_count", 72'(wr_seen), 72'(nwords));
      check("err_short", 72'(err_short), 72'(exp_short));
      check("err_long", 72'(err_long), 72'(exp_long));
      check("scoreboard_drained", 72'(exp_q.size()), 72'(0));
      check("idle_not_busy", 72'(busy), 72'(0));
      if (n == 0) check("zero_words_no_tready", 72'(ready_seen), 72'(0));
      exp_q.delete();
   endtask

   initial begin
      int n, req, kind, sb, cyc;
      logic [71:0] word;
      rst = 1'b1;
      start = 1'b0;
      num_words = '0;
      s_tdata = '0;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl_outputs", 72'({s_tready, wr_en, busy, done, err_short, err_long}), 72'(0));
      check("reset_wr_data", wr_data, 72'(0));
      rst = 1'b0;
      @(negedge clk);

      run_cmd(8, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      run_cmd(3, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      run_cmd(0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      run_cmd(16, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      run_cmd(16, 1, 0, 0, 1'b0, 1'b1, 1'b1);
      run_cmd(16, 0, 1, 4, 1'b1, 1'b0, 1'b0);
      run_cmd(5, 0, 0, 0, 1'b1, 1'b0, 1'b0);
      run_cmd(4, 0, 2, 0, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, 40);
         req = (9*n + 7) / 8;
         kind = $urandom_range(0, 2);
         sb = $urandom_range(0, req);
         run_cmd(n, 2, kind, sb, 1'b0, 1'b0, 1'b0);
      end

      // Reset in the middle of a 64-word load.
      stream.delete();
      for (int i = 0; i < 80 * 8; i++) stream.push_back(8'(i));
      for (int w = 0; w < 64; w++) begin
         for (int k = 0; k < 9; k++) word[8*k +: 8] = stream[9*w + k];
         exp_q.push_back(word);
      end
      wr_seen = 0;
      @(negedge clk);
      start = 1'b1;
      num_words = CW'(64);
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      s_tvalid = 1'b1;
      s_tlast = 1'b0;
      for (int b = 0; wr_seen < 5 && cyc < 300; ) begin
         s_tdata = beat_data(b);
         if (s_tready) b++;
         @(negedge clk);
         cyc++;
      end
      check("reached_word5", 72'(wr_seen >= 5), 72'(1));
      rst = 1'b1;
      s_tvalid = 1'b0;
      @(negedge clk);
      check("midload_rst_ctrl", 72'({s_tready, wr_en, busy, done, err_short, err_long}), 72'(0));
      check("midload_rst_wr_data", wr_data, 72'(0));
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      run_cmd(10, 0, 0, 0, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
